// File: rtl/instr_word_encoder.sv
// instr_word_encoder: packs decoded instruction fields into 32-bit words and
// streams them into instruction memory at consecutive word addresses. The
// processor is held off until the host commits the program.
module instr_word_encoder #(
  parameter int          DEPTH     = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  localparam int         CW        = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          commit,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_cond,
  input  logic [1:0]    in_op,
  input  logic [5:0]    in_funct,
  input  logic [3:0]    in_rn,
  input  logic [3:0]    in_rd,
  input  logic [11:0]   in_src2,
  input  logic [23:0]   in_imm24,
  output logic          imem_we,
  output logic [31:0]   imem_addr,
  output logic [31:0]   imem_wdata,
  output logic [CW-1:0] word_count,
  output logic          full,
  output logic          error,
  output logic          cpu_release
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    r_state;
  logic          r_we;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [CW-1:0] r_count;
  logic          r_error;

  logic          w_full;
  logic          w_ready;
  logic          w_accept;
  logic          w_illegal;
  logic [31:0]   w_word;
  logic [31:0]   w_addr;

  assign w_full    = (r_count == CW'(DEPTH));
  assign w_ready   = (r_state == S_LOAD) && !w_full;
  assign w_accept  = in_valid && w_ready;
  assign w_illegal = (in_op == 2'b11);
  // Word k of the session lands at BASE_ADDR + 4k; the add wraps mod 2^32.
  assign w_addr    = BASE_ADDR + (32'(r_count) << 2);

  // Field packing: branches carry a 24-bit offset, everything else the
  // funct/Rn/Rd/Src2 layout. op=11 never reaches memory, so its value is moot.
  always_comb begin
    w_word = {in_cond, in_op, in_funct, in_rn, in_rd, in_src2};
    if (in_op == 2'b10) w_word = {in_cond, 2'b10, 2'b10, in_imm24};
  end

  // Session FSM, counters, sticky error and the registered write port.
  // start has priority over commit and over a coincident field set: the
  // restart discards whatever was on the inputs that cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_count <= '0;
      r_error <= 1'b0;
    end else begin
      r_we <= 1'b0;
      if (start) begin
        r_state <= S_LOAD;
        r_count <= '0;
        r_error <= 1'b0;
      end else if (r_state == S_LOAD) begin
        if (w_accept) begin
          if (w_illegal) begin
            r_error <= 1'b1;
          end else begin
            r_we    <= 1'b1;
            r_addr  <= w_addr;
            r_wdata <= w_word;
            r_count <= r_count + CW'(1);
          end
        end
        // A word accepted alongside commit is still registered above.
        if (commit) r_state <= S_DONE;
      end
    end
  end

  assign in_ready    = w_ready;
  assign imem_we     = r_we;
  assign imem_addr   = r_addr;
  assign imem_wdata  = r_wdata;
  assign word_count  = r_count;
  assign full        = w_full;
  assign error       = r_error;
  assign cpu_release = (r_state == S_DONE);

endmodule

// File: tb/tb_instr_word_encoder.sv
// Directed bench for instr_word_encoder (DEPTH=4, BASE_ADDR=0).
module tb_instr_word_encoder;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset, start, commit, in_valid;
  logic          in_ready;
  logic [3:0]    in_cond;
  logic [1:0]    in_op;
  logic [5:0]    in_funct;
  logic [3:0]    in_rn, in_rd;
  logic [11:0]   in_src2;
  logic [23:0]   in_imm24;
  logic          imem_we;
  logic [31:0]   imem_addr, imem_wdata;
  logic [CW-1:0] word_count;
  logic          full, error, cpu_release;

  int n_cmp = 0;
  int n_err = 0;
  int writes;

  instr_word_encoder #(.DEPTH(DEPTH), .BASE_ADDR(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .start(start), .commit(commit),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_cond(in_cond), .in_op(in_op), .in_funct(in_funct),
    .in_rn(in_rn), .in_rd(in_rd), .in_src2(in_src2), .in_imm24(in_imm24),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .word_count(word_count), .full(full), .error(error),
    .cpu_release(cpu_release)
  );

  always #5 clk = ~clk;

  // Advance one rising edge; inputs change and outputs are sampled 1 time
  // unit after it, well away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic fields(input logic [3:0] c, input logic [1:0] op, input logic [5:0] f,
                        input logic [3:0] rn, input logic [3:0] rd,
                        input logic [11:0] s2, input logic [23:0] i24);
    in_cond = c; in_op = op; in_funct = f; in_rn = rn; in_rd = rd;
    in_src2 = s2; in_imm24 = i24;
  endtask

  // Hand-packed reference words:
  //   ADD_F0  cond=E op=00 funct=001000 rn=1 rd=2 src2=005 -> E0812005
  //   ADD_I   cond=E op=00 funct=101000 rn=1 rd=2 src2=005 -> E2812005
  //   LDR     cond=E op=01 funct=011001 rn=0 rd=3 src2=010 -> E5903010
  //   B       cond=E op=10 imm24=FFFFFE (junk in other fields) -> EAFFFFFE
  task automatic w_add_f0(); fields(4'hE, 2'b00, 6'b001000, 4'h1, 4'h2, 12'h005, 24'h0); endtask
  task automatic w_add_i();  fields(4'hE, 2'b00, 6'b101000, 4'h1, 4'h2, 12'h005, 24'h0); endtask
  task automatic w_ldr();    fields(4'hE, 2'b01, 6'b011001, 4'h0, 4'h3, 12'h010, 24'h0); endtask
  task automatic w_br();     fields(4'hE, 2'b10, 6'h3F, 4'hF, 4'hF, 12'hFFF, 24'hFFFFFE); endtask
  task automatic w_bad();    fields(4'hE, 2'b11, 6'h00, 4'h1, 4'h1, 12'h001, 24'h0); endtask

  initial begin
    reset = 1'b0; start = 1'b0; commit = 1'b0; in_valid = 1'b0;
    w_add_f0();

    // Reset state
    step(); step();
    check("rst_we",    32'(imem_we),     32'd0);
    check("rst_addr",  imem_addr,        32'd0);
    check("rst_wdata", imem_wdata,       32'd0);
    check("rst_count", 32'(word_count),  32'd0);
    check("rst_full",  32'(full),        32'd0);
    check("rst_error", 32'(error),       32'd0);
    check("rst_rel",   32'(cpu_release), 32'd0);
    check("rst_ready", 32'(in_ready),    32'd0);

    // Single word; funct bit 25 clear gives E0812005 under the field layout
    reset = 1'b1;
    step();
    check("idle_ready", 32'(in_ready), 32'd0);
    start = 1'b1; step(); start = 1'b0;
    check("load_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1; step(); in_valid = 1'b0;
    check("w1_we",    32'(imem_we),    32'd1);
    check("w1_addr",  imem_addr,       32'h0);
    check("w1_wdata", imem_wdata,      32'hE0812005);
    check("w1_count", 32'(word_count), 32'd1);
    step();
    check("w1_we_off",  32'(imem_we), 32'd0);
    check("w1_hold",    imem_wdata,   32'hE0812005);

    // Restart in LOAD, then three back-to-back words
    start = 1'b1; step(); start = 1'b0;
    check("restart_count", 32'(word_count), 32'd0);
    in_valid = 1'b1; w_add_i(); step();
    check("b0_we",    32'(imem_we), 32'd1);
    check("b0_addr",  imem_addr,    32'h0);
    check("b0_wdata", imem_wdata,   32'hE2812005);
    w_ldr(); step();
    check("b1_we",    32'(imem_we), 32'd1);
    check("b1_addr",  imem_addr,    32'h4);
    check("b1_wdata", imem_wdata,   32'hE5903010);
    w_br(); step(); in_valid = 1'b0;
    check("b2_we",    32'(imem_we),    32'd1);
    check("b2_addr",  imem_addr,       32'h8);
    check("b2_wdata", imem_wdata,      32'hEAFFFFFE);
    check("b2_count", 32'(word_count), 32'd3);
    commit = 1'b1; step(); commit = 1'b0;
    check("c3_rel",   32'(cpu_release), 32'd1);
    check("c3_ready", 32'(in_ready),    32'd0);
    check("c3_we",    32'(imem_we),     32'd0);
    commit = 1'b1; step(); commit = 1'b0;
    check("done_commit_ignored", 32'(cpu_release), 32'd1);

    // Fill to DEPTH with in_valid held for six cycles
    start = 1'b1; step(); start = 1'b0;
    check("fill_rel",   32'(cpu_release), 32'd0);
    check("fill_count", 32'(word_count),  32'd0);
    in_valid = 1'b1; w_add_i();
    writes = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (imem_we) writes++;
    end
    check("fill_writes", 32'(writes),      32'd4);
    check("fill_full",   32'(full),        32'd1);
    check("fill_ready",  32'(in_ready),    32'd0);
    check("fill_count4", 32'(word_count),  32'd4);
    check("fill_last",   imem_addr,        32'hC);
    commit = 1'b1; step(); commit = 1'b0; in_valid = 1'b0;
    check("fill_rel1",   32'(cpu_release), 32'd1);
    check("fill_we0",    32'(imem_we),     32'd0);

    // Illegal op between two legal words
    start = 1'b1; step(); start = 1'b0;
    in_valid = 1'b1; w_add_i(); step();
    check("il_w0_addr", imem_addr, 32'h0);
    w_bad(); step();
    check("il_we",    32'(imem_we),    32'd0);
    check("il_error", 32'(error),      32'd1);
    check("il_count", 32'(word_count), 32'd1);
    w_ldr(); step(); in_valid = 1'b0;
    check("il_w1_we",   32'(imem_we),    32'd1);
    check("il_w1_addr", imem_addr,       32'h4);
    check("il_count2",  32'(word_count), 32'd2);
    check("il_sticky",  32'(error),      32'd1);
    start = 1'b1; step(); start = 1'b0;
    check("il_clear", 32'(error), 32'd0);

    // commit coinciding with an accepted word
    in_valid = 1'b1; commit = 1'b1; w_br(); step();
    in_valid = 1'b0; commit = 1'b0;
    check("cw_we",    32'(imem_we),     32'd1);
    check("cw_addr",  imem_addr,        32'h0);
    check("cw_wdata", imem_wdata,       32'hEAFFFFFE);
    check("cw_rel",   32'(cpu_release), 32'd1);
    step();
    check("cw_we0",   32'(imem_we), 32'd0);

    // Reset mid-stream cancels the pending write
    start = 1'b1; step(); start = 1'b0;
    in_valid = 1'b1; w_add_i(); step();
    check("mr_pre_we", 32'(imem_we), 32'd1);
    w_ldr(); reset = 1'b0; step();
    check("mr_we",    32'(imem_we),     32'd0);
    check("mr_addr",  imem_addr,        32'd0);
    check("mr_wdata", imem_wdata,       32'd0);
    check("mr_count", 32'(word_count),  32'd0);
    check("mr_ready", 32'(in_ready),    32'd0);
    reset = 1'b1; step();
    check("mr_idle_we", 32'(imem_we), 32'd0);
    in_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
